// File: rtl/datapath_controller_pkg.sv
// rtl/datapath_controller_pkg.sv - state, opcode, ALU encodings and instruction field positions
package datapath_controller_pkg;

  typedef enum logic [3:0] {
    S_WAIT   = 4'd0,
    S_DECODE = 4'd1,
    S_WIMM   = 4'd2,
    S_GETA   = 4'd3,
    S_GETB   = 4'd4,
    S_OPER   = 4'd5,
    S_CMP    = 4'd6,
    S_WB     = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    I_MOVI, I_MOVR, I_ADD, I_CMP, I_AND, I_MVN, I_ILL
  } instr_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  localparam int IMM5_W  = 5;
  localparam int IMM8_W  = 8;

endpackage

// File: rtl/datapath_controller_instr_decoder.sv
// rtl/datapath_controller_instr_decoder.sv - combinational split of the latched instruction
// into register fields, sign-extended immediates and an instruction class.
module datapath_controller_instr_decoder
  import datapath_controller_pkg::*;
#(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic [IW-1:0] ir,
  output logic [RW-1:0] rn,
  output logic [RW-1:0] rd,
  output logic [RW-1:0] rm,
  output logic [1:0]    op,
  output logic [1:0]    sh,
  output logic [IW-1:0] sximm5,
  output logic [IW-1:0] sximm8,
  output instr_t        kind,
  output logic          legal
);

  assign rn = ir[RN_LSB +: RW];
  assign rd = ir[RD_LSB +: RW];
  assign rm = ir[RM_LSB +: RW];
  assign op = ir[OP_LSB +: 2];
  assign sh = ir[SH_LSB +: 2];

  assign sximm5 = {{(IW-IMM5_W){ir[IMM5_W-1]}}, ir[IMM5_W-1:0]};
  assign sximm8 = {{(IW-IMM8_W){ir[IMM8_W-1]}}, ir[IMM8_W-1:0]};

  always_comb begin
    kind = I_ILL;
    case ({ir[OPC_LSB +: 3], ir[OP_LSB +: 2]})
      {OPC_MOV, OP_MOV_IMM}: kind = I_MOVI;
      {OPC_MOV, OP_MOV_REG}: kind = I_MOVR;
      {OPC_ALU, OP_ADD}:     kind = I_ADD;
      {OPC_ALU, OP_CMP}:     kind = I_CMP;
      {OPC_ALU, OP_AND}:     kind = I_AND;
      {OPC_ALU, OP_MVN}:     kind = I_MVN;
      default:               kind = I_ILL;
    endcase
  end

  assign legal = (kind != I_ILL);

endmodule

// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - instruction latch and multi-cycle sequencer for the reg/shift/ALU datapath.
// Define CTRL_ILLEGAL_TRAP_EN to park illegal instructions in S_TRAP with err=1 until reset.
module datapath_controller
  import datapath_controller_pkg::*;
#(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [IW-1:0] in,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] sximm5,
  output logic [IW-1:0] sximm8,
  output logic          err
);

  state_t          state, next;
  logic [IW-1:0]   ir;
  logic [RW-1:0]   rn, rd, rm;
  logic [1:0]      op, sh;
  instr_t          kind;
  logic            legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_WAIT && s) ir <= in;
    end
  end

  datapath_controller_instr_decoder #(.IW(IW), .RW(RW)) u_instr_decoder (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .op     (op),
    .sh     (sh),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .kind   (kind),
    .legal  (legal)
  );

  always_comb begin
    next     = state;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    err      = 1'b0;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) next = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          next = S_TRAP;
`else
          next = S_WAIT;
`endif
        end else begin
          case (kind)
            I_MOVI:        next = S_WIMM;
            I_MOVR, I_MVN: next = S_GETB;
            default:       next = S_GETA;
          endcase
        end
      end
      S_WIMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
        next     = S_WAIT;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
        next    = S_GETB;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        next    = (kind == I_CMP) ? S_CMP : S_OPER;
      end
      S_OPER: begin
        loadc = 1'b1;
        shift = sh;
        // MOV reg reuses the adder with A forced to zero
        if (kind == I_MOVR) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else begin
          ALUop = op;
        end
        next = S_WB;
      end
      S_CMP: begin
        shift = sh;
        ALUop = ALU_SUB;
        loads = 1'b1;
        next  = S_WAIT;
      end
      S_WB: begin
        writenum = rd;
        write    = 1'b1;
        next     = S_WAIT;
      end
      S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        err  = 1'b1;
        next = S_TRAP;
`else
        next = S_WAIT;
`endif
      end
      default: next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// tb/tb_datapath_controller.sv - scoreboard bench for datapath_controller
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] in;
  logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel, err;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm5, sximm8;

  always #5 clk = ~clk;

  datapath_controller dut (
    .clk(clk), .reset(reset), .s(s), .in(in), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8), .err(err)
  );

  typedef struct packed {
    logic       w, err, write, loada, loadb, loadc, loads;
    logic [2:0] readnum, writenum;
    logic       vsel, asel, bsel;
    logic [1:0] shift, aluop;
    logic [15:0] sx5, sx8;
  } ctl_t;

  typedef struct {
    ctl_t        v;
    ctl_t        m;
    logic [15:0] instr;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  function automatic ctl_t sample();
    ctl_t a;
    a.w = w; a.err = err; a.write = write; a.loada = loada; a.loadb = loadb;
    a.loadc = loadc; a.loads = loads; a.readnum = readnum; a.writenum = writenum;
    a.vsel = vsel; a.asel = asel; a.bsel = bsel; a.shift = shift; a.aluop = ALUop;
    a.sx5 = sximm5; a.sx8 = sximm8;
    return a;
  endfunction

  // 0 MOVimm, 1 MOVreg, 2 ADD, 3 CMP, 4 AND, 5 MVN, -1 illegal
  function automatic int cls_of(input logic [15:0] ins);
    case ({ins[15:13], ins[12:11]})
      5'b110_10: return 0;
      5'b110_00: return 1;
      5'b101_00: return 2;
      5'b101_01: return 3;
      5'b101_10: return 4;
      5'b101_11: return 5;
      default:   return -1;
    endcase
  endfunction

  function automatic void add(input logic [15:0] ins, input int idx, input ctl_t v, input ctl_t m);
    exp_t e;
    e.v = v; e.m = m; e.instr = ins; e.idx = idx;
    exp_q.push_back(e);
  endfunction

  // Expected per-cycle controls from the s edge until idle, built from the instruction's micro-ops.
  function automatic int push_model(input logic [15:0] ins);
    int         cls = cls_of(ins);
    int         v5  = int'(ins[4:0]);
    int         v8  = int'(ins[7:0]);
    logic [2:0] rn  = ins[10:8];
    logic [2:0] rd  = ins[7:5];
    logic [2:0] rm  = ins[2:0];
    logic [1:0] op  = ins[12:11];
    logic [1:0] sh  = ins[4:3];
    ctl_t b, mb, r, m;
    int n = 0;
    if (v5 > 15) v5 -= 32;
    if (v8 > 127) v8 -= 256;
    b = '0; b.sx5 = 16'(v5); b.sx8 = 16'(v8);
    mb = '0; mb.w = 1; mb.err = 1; mb.write = 1; mb.loada = 1; mb.loadb = 1;
    mb.loadc = 1; mb.loads = 1; mb.sx5 = '1; mb.sx8 = '1;
    add(ins, n, b, mb); n++;
    if (cls == 0) begin
      r = b; r.write = 1; r.writenum = rn; r.vsel = 1;
      m = mb; m.writenum = '1; m.vsel = 1;
      add(ins, n, r, m); n++;
    end else if (cls > 0) begin
      m = mb; m.readnum = '1;
      if (cls == 2 || cls == 3 || cls == 4) begin
        r = b; r.loada = 1; r.readnum = rn;
        add(ins, n, r, m); n++;
      end
      r = b; r.loadb = 1; r.readnum = rm;
      add(ins, n, r, m); n++;
      r = b; r.shift = sh;
      m = mb; m.asel = 1; m.bsel = 1; m.shift = '1; m.aluop = '1;
      if (cls == 3) begin
        r.loads = 1; r.aluop = 2'b01;
      end else begin
        r.loadc = 1; r.asel = (cls == 1); r.aluop = (cls == 1) ? 2'b00 : op;
      end
      add(ins, n, r, m); n++;
      if (cls != 3) begin
        r = b; r.write = 1; r.writenum = rd; r.vsel = 0;
        m = mb; m.writenum = '1; m.vsel = 1;
        add(ins, n, r, m); n++;
      end
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      r = b; r.err = 1;
      repeat (10) begin add(ins, n, r, mb); n++; end
      return n;
`endif
    end
    r = b; r.w = 1;
    add(ins, n, r, mb); n++;
    return n;
  endfunction

  always @(negedge clk) begin
    ctl_t a;
    exp_t e;
    if (!reset) begin
      a = sample();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("instr %h cycle %0d", e.instr, e.idx), 64'(a & e.m), 64'(e.v & e.m));
      end else begin
        chk("idle", 64'({a.w, a.err, a.write, a.loada, a.loadb, a.loadc, a.loads}), 64'(7'b1000000));
      end
    end
  end

  // mode 0: s low while busy; 1: random s and junk instruction while busy; 2: s held high
  task automatic run_instr(input logic [15:0] ins, input int mode);
    int n;
    in = ins; s = 1;
    @(posedge clk); #1;
    n = push_model(ins);
    for (int k = 0; k < n - 1; k++) begin
      if (mode == 0) s = 0;
      else begin
        s  = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        in = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    s = (mode == 2);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " w"}, 64'(w), 64'(1));
    chk({tag, " enables"}, 64'({write, loada, loadb, loadc, loads}), 64'(0));
    chk({tag, " muxes"}, 64'({asel, bsel, vsel}), 64'(0));
    chk({tag, " regnums"}, 64'({readnum, writenum}), 64'(0));
    chk({tag, " err"}, 64'(err), 64'(0));
  endtask

  function automatic logic [15:0] rand_instr(input bit allow_illegal);
    int          c;
    logic [15:0] ins;
    c = allow_illegal ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 5));
    ins = 16'($urandom);
    case (c)
      0: ins[15:11] = 5'b110_10;
      1: ins[15:11] = 5'b110_00;
      2: ins[15:11] = 5'b101_00;
      3: ins[15:11] = 5'b101_01;
      4: ins[15:11] = 5'b101_10;
      5: ins[15:11] = 5'b101_11;
      default: while (cls_of(ins) >= 0) ins = 16'($urandom);
    endcase
    return ins;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int mode;
    bit allow_ill;
    reset = 1; s = 0; in = '0;
    repeat (2) @(posedge clk); #1;
    check_reset("reset");
    chk("reset sximm8", 64'(sximm8), 64'(0));
    chk("reset sximm5", 64'(sximm5), 64'(0));
    reset = 0;
    @(posedge clk); #1;

    run_instr(16'hD007, 0);
    run_instr(16'hD380, 0);
    run_instr(16'hA148, 0);
    run_instr(16'hA900, 0);

    // reset while ADD sits in its operate cycle
    in = 16'hA148; s = 1;
    @(posedge clk); #1;
    void'(push_model(16'hA148));
    s = 0;
    repeat (4) @(negedge clk);
    #1;
    reset = 1;
    exp_q.delete();
    #1;
    check_reset("mid-op reset");
    @(posedge clk); #1;
    reset = 0;
    repeat (2) @(posedge clk); #1;
    run_instr(16'hD007, 0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    allow_ill = 0;
`else
    allow_ill = 1;
`endif
    for (int i = 0; i < 60; i++) begin
      mode = (i == 59) ? 0 : int'($urandom_range(0, 2));
      run_instr(rand_instr(allow_ill), mode);
      if (mode != 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    run_instr(16'hE000, 1);
    s = 0;
    @(negedge clk); #1;
    reset = 1;
    #1;
    check_reset("trap reset");
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    run_instr(16'hD007, 0);
`else
    run_instr(16'hE000, 0);
    run_instr(16'hE000, 1);
`endif

    repeat (3) @(posedge clk); #1;
    chk("queue drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
